// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports plus data-memory bus of the arbiter.
// The master side is the requesters and memory; the slave side is the arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port not granted most recently wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_is_1,
  output logic [NUM_PORTS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || last_is_1)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-cycle data memory; one access per cycle,
// read data returned two cycles after the grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
)(
  input logic        clk,
  input logic        rst_n,
  mem_arbiter_if.slave bus
);

  arb_state_e                  state_q, state_d;
  logic                        last_q, last_d;
  logic                        owner_q, owner_d;
  logic                        mem_read_q, mem_read_d;
  logic                        mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
  logic [NUM_PORTS-1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0]           rdata0_q, rdata0_d;
  logic [DATA_W-1:0]           rdata1_q, rdata1_d;

  logic [NUM_PORTS-1:0]        gnt_raw;
  logic                        accept;
  logic                        sel_we;
  logic [ADDR_W-1:0]           sel_addr;
  logic [DATA_W-1:0]           sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req       ({bus.req1, bus.req0}),
    .last_is_1 (last_q),
    .gnt       (gnt_raw)
  );

  // Flops are held in reset anyway, so only the visible grants need gating.
  assign bus.gnt0 = gnt_raw[0] & rst_n;
  assign bus.gnt1 = gnt_raw[1] & rst_n;

  assign accept    = |gnt_raw;
  assign sel_we    = gnt_raw[1] ? bus.we1    : bus.we0;
  assign sel_addr  = gnt_raw[1] ? bus.addr1  : bus.addr0;
  assign sel_wdata = gnt_raw[1] ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d     = IDLE;
    last_d      = last_q;
    owner_d     = owner_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rvalid_d    = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      IDLE:    state_d = accept ? ACCESS : IDLE;
      ACCESS:  state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      owner_d     = gnt_raw[1];
      last_d      = gnt_raw[1];
      mem_read_d  = ~sel_we;
      mem_write_d = sel_we;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
    end

    // Capture read data at the end of the access cycle for its owner only.
    if ((state_q == ACCESS) && mem_read_q) begin
      if (owner_q) begin
        rvalid_d[1] = 1'b1;
        rdata1_d    = bus.mem_rdata;
      end else begin
        rvalid_d[0] = 1'b1;
        rdata0_d    = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rvalid_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rvalid0   = rvalid_q[0];
  assign bus.rvalid1   = rvalid_q[1];
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model (round-robin choice, ordered memory, fixed latencies).
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // Memory: combinational read, write at the end of the strobe cycle
  logic [31:0] mem [256];
  bit          written [256];
  assign bus.mem_rdata = !bus.mem_read ? '0 :
                         (written[bus.mem_addr[7:0]] ? mem[bus.mem_addr[7:0]]
                                                     : init_val(bus.mem_addr[7:0]));
  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr[7:0]]     <= bus.mem_wdata;
      written[bus.mem_addr[7:0]] <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [256];
  int          last_port;
  bit          acc_v, acc_we, acc_own;
  logic [31:0] acc_rdata;
  bit          rsp_v, rsp_own;
  logic [31:0] exp_rdata [2];
  logic [31:0] exp_maddr, exp_mwdata;

  task automatic model_reset();
    last_port    = 1;
    acc_v        = 0;
    rsp_v        = 0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_maddr    = '0;
    exp_mwdata   = '0;
  endtask

  task automatic drive_idle();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  // One clock cycle: drive requests, check everything visible this cycle, advance model.
  task automatic cycle(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                       output bit g0, output bit g1);
    bit eg0, eg1, own, we;
    logic [31:0] a, d;
    @(negedge clk);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    #1;
    eg0 = r0 && (!r1 || last_port == 1);
    eg1 = r1 && !eg0;
    check_eq("gnt0", 32'(bus.gnt0), 32'(eg0));
    check_eq("gnt1", 32'(bus.gnt1), 32'(eg1));
    check_eq("mem_read", 32'(bus.mem_read), 32'(acc_v && !acc_we));
    check_eq("mem_write", 32'(bus.mem_write), 32'(acc_v && acc_we));
    check_eq("mem_addr", bus.mem_addr, exp_maddr);
    check_eq("mem_wdata", bus.mem_wdata, exp_mwdata);
    check_eq("rvalid0", 32'(bus.rvalid0), 32'(rsp_v && !rsp_own));
    check_eq("rvalid1", 32'(bus.rvalid1), 32'(rsp_v && rsp_own));
    check_eq("rdata0", bus.rdata0, exp_rdata[0]);
    check_eq("rdata1", bus.rdata1, exp_rdata[1]);
    if (acc_v && !acc_we) begin
      rsp_v = 1; rsp_own = acc_own; exp_rdata[acc_own] = acc_rdata;
    end else begin
      rsp_v = 0;
    end
    if (eg0 || eg1) begin
      own = eg1;
      we  = own ? w1 : w0;
      a   = own ? a1 : a0;
      d   = own ? d1 : d0;
      if (we) ref_mem[a[7:0]] = d;
      else    acc_rdata = ref_mem[a[7:0]];
      acc_v = 1; acc_we = we; acc_own = own;
      exp_maddr = a; exp_mwdata = d;
      last_port = int'(own);
    end else begin
      acc_v = 0;
    end
    g0 = eg0;
    g1 = eg1;
  endtask

  task automatic idle_cycle();
    bit g0, g1;
    cycle(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    drive_idle();
    #1;
    check_eq("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check_eq("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    check_eq("rst_rdata1", bus.rdata1, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    bit g0, g1;
    bit          p_v [2];
    bit          p_we [2];
    logic [31:0] p_a [2];
    logic [31:0] p_d [2];

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    rst_n = 0;
    drive_idle();
    model_reset();
    do_reset();
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);

    // Simultaneous reads after reset: port 0 first, then port 1
    cycle(1, 0, 32'd0, '0, 1, 0, 32'd10, '0, g0, g1);
    check_eq("tie_first_p0", 32'(bus.gnt0), 32'd1);
    cycle(0, 0, '0, '0, 1, 0, 32'd10, '0, g0, g1);
    check_eq("held_p1_gnt", 32'(bus.gnt1), 32'd1);
    idle_cycle();
    check_eq("dual_rv0", 32'(bus.rvalid0), 32'd1);
    check_eq("dual_rd0", bus.rdata0, 32'hA000_0000);
    idle_cycle();
    check_eq("dual_rv1", 32'(bus.rvalid1), 32'd1);
    check_eq("dual_rd1", bus.rdata1, 32'hA000_000A);

    // Port 0 write then read same address
    do_reset();
    cycle(1, 1, 32'd10, 32'd200, 0, 0, '0, '0, g0, g1);
    cycle(1, 0, 32'd10, '0, 0, 0, '0, '0, g0, g1);
    check_eq("wr_strobe", 32'(bus.mem_write), 32'd1);
    idle_cycle();
    check_eq("rd_strobe", 32'(bus.mem_read), 32'd1);
    idle_cycle();
    check_eq("wr_rd_rv0", 32'(bus.rvalid0), 32'd1);
    check_eq("wr_rd_data", bus.rdata0, 32'd200);
    idle_cycle();
    check_eq("rv0_one_pulse", 32'(bus.rvalid0), 32'd0);

    // Continuous contention: strict alternation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1, i[1], 32'(i), 32'(i * 3), 1, ~i[1], 32'(i + 1), 32'(i * 5), g0, g1);
      check_eq("alt_gnt0", 32'(bus.gnt0), 32'((i % 2) == 0));
      if (i > 0) check_eq("alt_strobe", 32'(bus.mem_read | bus.mem_write), 32'd1);
    end
    idle_cycle();
    idle_cycle();

    // Port 1 write followed by port 0 read of the same word
    do_reset();
    cycle(0, 0, '0, '0, 1, 1, 32'd4, 32'hDEAD_BEEF, g0, g1);
    cycle(1, 0, 32'd4, '0, 0, 0, '0, '0, g0, g1);
    idle_cycle();
    idle_cycle();
    check_eq("fwd_rv0", 32'(bus.rvalid0), 32'd1);
    check_eq("fwd_data", bus.rdata0, 32'hDEAD_BEEF);

    // Reset in the middle of a read access
    do_reset();
    cycle(1, 0, 32'd3, '0, 0, 0, '0, '0, g0, g1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_eq("abort_mem_read", 32'(bus.mem_read), 32'd0);
    check_eq("abort_rvalid0", 32'(bus.rvalid0), 32'd0);
    check_eq("abort_rvalid1", 32'(bus.rvalid1), 32'd0);
    check_eq("abort_gnt0", 32'(bus.gnt0), 32'd0);
    repeat (2) @(negedge clk);
    drive_idle();
    rst_n = 1;
    model_reset();
    repeat (3) idle_cycle();
    cycle(1, 0, 32'd1, '0, 1, 0, 32'd2, '0, g0, g1);
    check_eq("post_rst_tie", 32'(bus.gnt0), 32'd1);
    cycle(0, 0, '0, '0, 1, 0, 32'd2, '0, g0, g1);
    idle_cycle();
    idle_cycle();

    // Random traffic; each requester holds its request until granted
    for (int p = 0; p < 2; p++) begin
      p_v[p] = 0; p_we[p] = 0; p_a[p] = '0; p_d[p] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_v[p] && $urandom_range(99) < 60) begin
          p_v[p]  = 1;
          p_we[p] = 1'($urandom_range(1));
          p_a[p]  = 32'($urandom_range(15));
          p_d[p]  = $urandom;
        end
      end
      cycle(p_v[0], p_we[0], p_a[0], p_d[0], p_v[1], p_we[1], p_a[1], p_d[1], g0, g1);
      if (g0) p_v[0] = 0;
      if (g1) p_v[1] = 0;
    end
    repeat (3) idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
